// File: rtl/driver_cell_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : driver_cell_pkg
// Brief    : Shared state encoding, supply references and window check for
//            the clocked DAC switch driver.
// Revision : 1.0
// ============================================================================
package driver_cell_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WAKE   = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } drv_state_t;

    localparam real c_VDD1P8_NOM = 1.8;
    localparam real c_VDD0P8_NOM = 0.8;
    localparam real c_VSS_NOM    = 0.0;

    // Absorbs binary rounding of products like 1.8*1.05 so exact limits pass.
    localparam real c_WIN_EPS = 1.0e-9;

    function automatic logic in_window(input real v, input real lo, input real hi);
        return (v >= lo - c_WIN_EPS) && (v <= hi + c_WIN_EPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/driver_cell_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : driver_cell_pipe
// Brief    : Synchronously reset WIDTH-bit delay line of STAGES registers.
// Revision : 1.0
// ============================================================================
module driver_cell_pipe #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            if (g == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) r_stage[g] <= '0;
                    else     r_stage[g] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) r_stage[g] <= '0;
                    else     r_stage[g] <= r_stage[g-1];
                end
            end
        end
    endgenerate

    assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/driver_cell_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : driver_cell_sync
// Brief    : Retimed complementary switch driver with power sequencing and
//            supply-fault gating. Optional macro DRIVER_JITTER_EN (sim only)
//            adds per-bus Gaussian output delay, sigma JIT_SIGMA_PS.
// Revision : 1.0
// ============================================================================
module driver_cell_sync
    import driver_cell_pkg::*;
#(
    parameter int  NBIN        = 7,
    parameter int  NTHERM      = 17,
    parameter int  PIPE_STAGES = 2,
    parameter int  T_WAKE      = 8,
    parameter int  T_DRAIN     = 4,
    parameter real SUP_TOL     = 0.05,
    parameter real VSS_TOL     = 0.05
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pdb,
    input  real               vddana_1p8,
    input  real               vddana_0p8,
    input  real               vssana,
    input  logic [NBIN-1:0]   datain,
    input  logic [NBIN-1:0]   datainb,
    input  logic [NTHERM-1:0] datatherm,
    input  logic [NTHERM-1:0] datathermb,
    output logic [NBIN-1:0]   databinout,
    output logic [NBIN-1:0]   databinoutb,
    output logic [NTHERM-1:0] datathermout,
    output logic [NTHERM-1:0] datathermoutb,
    output logic              ready,
    output logic              code_err,
    output logic              supply_fault
);

    localparam int c_CNT_MAX = (T_WAKE > T_DRAIN) ? T_WAKE : T_DRAIN;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    drv_state_t               r_state;
    logic [c_CW-1:0]          r_cnt;
    logic                     r_pdb_meta;
    logic                     r_pdb_s;
    logic                     r_code_err;
    logic                     r_supply_fault;
    logic                     w_supply_ok;
    logic                     w_code_mismatch;
    logic                     w_drive;
    logic [NTHERM+NBIN-1:0]   w_pipe_q;
    logic [NBIN-1:0]          w_bin;
    logic [NTHERM-1:0]        w_therm;

    assign w_supply_ok =
        in_window(vddana_1p8, c_VDD1P8_NOM * (1.0 - SUP_TOL), c_VDD1P8_NOM * (1.0 + SUP_TOL)) &&
        in_window(vddana_0p8, c_VDD0P8_NOM * (1.0 - SUP_TOL), c_VDD0P8_NOM * (1.0 + SUP_TOL)) &&
        in_window(vssana, c_VSS_NOM - VSS_TOL, c_VSS_NOM + VSS_TOL);

    assign w_code_mismatch = (datainb != ~datain) || (datathermb != ~datatherm);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pdb_meta <= 1'b0;
            r_pdb_s    <= 1'b0;
        end else begin
            r_pdb_meta <= pdb;
            r_pdb_s    <= r_pdb_meta;
        end
    end

    driver_cell_pipe #(
        .WIDTH  (NTHERM + NBIN),
        .STAGES (PIPE_STAGES)
    ) u_pipe (
        .clk (clk),
        .rst (rst),
        .d   ({datatherm, datain}),
        .q   (w_pipe_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= OFF;
            r_cnt          <= '0;
            r_code_err     <= 1'b0;
            r_supply_fault <= 1'b0;
        end else begin
            if (r_state == ACTIVE && w_code_mismatch) r_code_err <= 1'b1;
            if (r_state == OFF) begin
                if (r_pdb_s && w_supply_ok) begin
                    r_state <= WAKE;
                    r_cnt   <= c_CW'(T_WAKE - 1);
                end
            end else if (!w_supply_ok) begin
                // Supply loss overrides pdb and counter events.
                r_state        <= OFF;
                r_cnt          <= '0;
                r_supply_fault <= 1'b1;
            end else begin
                case (r_state)
                    WAKE: begin
                        if (!r_pdb_s) begin
                            r_state <= DRAIN;
                            r_cnt   <= c_CW'(T_DRAIN - 1);
                        end else if (r_cnt == '0) begin
                            r_state <= ACTIVE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (!r_pdb_s) begin
                            r_state <= DRAIN;
                            r_cnt   <= c_CW'(T_DRAIN - 1);
                        end
                    end
                    default: begin
                        if (r_cnt == '0) r_state <= OFF;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                endcase
            end
        end
    end

    assign ready        = (r_state == ACTIVE);
    assign code_err     = r_code_err;
    assign supply_fault = r_supply_fault;
    assign w_drive      = (r_state != OFF);
    assign w_bin        = ready ? w_pipe_q[NBIN-1:0]           : '0;
    assign w_therm      = ready ? w_pipe_q[NTHERM+NBIN-1:NBIN] : '0;

`ifdef DRIVER_JITTER_EN
`ifndef JIT_SIGMA_PS
`define JIT_SIGMA_PS 1
`endif
    integer r_seed = 1;
    logic [NBIN-1:0]   w_bin_o, w_binb_o;
    logic [NTHERM-1:0] w_therm_o, w_thermb_o;
    logic [NBIN-1:0]   r_bin_j, r_binb_j;
    logic [NTHERM-1:0] r_therm_j, r_thermb_j;

    assign w_bin_o    = w_drive ? w_bin    : 'z;
    assign w_binb_o   = w_drive ? ~w_bin   : 'z;
    assign w_therm_o  = w_drive ? w_therm  : 'z;
    assign w_thermb_o = w_drive ? ~w_therm : 'z;

    // Each bus draws its own clamped delay sample on every update.
    always @(w_bin_o) begin : p_jit_bin
        integer d;
        d = $dist_normal(r_seed, 0, `JIT_SIGMA_PS);
        if (d < 0) d = 0;
        r_bin_j <= #(d * 1ps) w_bin_o;
    end
    always @(w_binb_o) begin : p_jit_binb
        integer d;
        d = $dist_normal(r_seed, 0, `JIT_SIGMA_PS);
        if (d < 0) d = 0;
        r_binb_j <= #(d * 1ps) w_binb_o;
    end
    always @(w_therm_o) begin : p_jit_therm
        integer d;
        d = $dist_normal(r_seed, 0, `JIT_SIGMA_PS);
        if (d < 0) d = 0;
        r_therm_j <= #(d * 1ps) w_therm_o;
    end
    always @(w_thermb_o) begin : p_jit_thermb
        integer d;
        d = $dist_normal(r_seed, 0, `JIT_SIGMA_PS);
        if (d < 0) d = 0;
        r_thermb_j <= #(d * 1ps) w_thermb_o;
    end

    assign databinout    = r_bin_j;
    assign databinoutb   = r_binb_j;
    assign datathermout  = r_therm_j;
    assign datathermoutb = r_thermb_j;
`else
    assign databinout    = w_drive ? w_bin    : 'z;
    assign databinoutb   = w_drive ? ~w_bin   : 'z;
    assign datathermout  = w_drive ? w_therm  : 'z;
    assign datathermoutb = w_drive ? ~w_therm : 'z;
`endif

endmodule
`default_nettype wire

// File: tb/tb_driver_cell_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_driver_cell_sync
// Brief    : Self-checking bench for driver_cell_sync (default and small
//            PIPE_STAGES=1 instances sharing control and supplies).
// Revision : 1.0
// ============================================================================
module tb_driver_cell_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pdb = 1'b0;
    real  v18 = 1.8;
    real  v08 = 0.8;
    real  vss = 0.0;

    logic [6:0]  din   = '0, dinb   = '1;
    logic [16:0] dth   = '0, dthb   = '1;
    logic [3:0]  s_din = '0, s_dinb = '1;
    logic [2:0]  s_dth = '0, s_dthb = '1;

    wire [6:0]  bo, bob;
    wire [16:0] to, tob;
    wire        rdy, cerr, sfault;
    wire [3:0]  s_bo, s_bob;
    wire [2:0]  s_to, s_tob;
    wire        s_rdy, s_cerr, s_sfault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    driver_cell_sync dut (
        .clk(clk), .rst(rst), .pdb(pdb),
        .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
        .datain(din), .datainb(dinb), .datatherm(dth), .datathermb(dthb),
        .databinout(bo), .databinoutb(bob), .datathermout(to), .datathermoutb(tob),
        .ready(rdy), .code_err(cerr), .supply_fault(sfault)
    );

    driver_cell_sync #(.NBIN(4), .NTHERM(3), .PIPE_STAGES(1)) dut_s (
        .clk(clk), .rst(rst), .pdb(pdb),
        .vddana_1p8(v18), .vddana_0p8(v08), .vssana(vss),
        .datain(s_din), .datainb(s_dinb), .datatherm(s_dth), .datathermb(s_dthb),
        .databinout(s_bo), .databinoutb(s_bob), .datathermout(s_to), .datathermoutb(s_tob),
        .ready(s_rdy), .code_err(s_cerr), .supply_fault(s_sfault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [6:0] b, input logic [16:0] t);
        din = b; dinb = ~b; dth = t; dthb = ~t;
    endtask

    // Undriven (high-Z) outputs never form a complementary pair.
    function automatic logic undriven();
        return (bob !== ~bo) && (tob !== ~to);
    endfunction

    task automatic chk_undriven(input string name);
        checks++;
        if (!undriven()) begin
            errors++;
            $display("FAIL %s: bin=%h binb=%h therm=%h thermb=%h, required undriven", name, bo, bob, to, tob);
        end
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (bo !== 7'h00 || bob !== 7'h7F || to !== 17'h0 || tob !== 17'h1FFFF || rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s: bin=%h binb=%h therm=%h thermb=%h ready=%b, required zero-code ready=0",
                     name, bo, bob, to, tob, rdy);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 40; i++) begin
            if (rdy === 1'b1) break;
            tick();
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s: ready=%b after 40 cycles, required 1", name, rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pdb = 1'b0;
        tick(); tick();
        checks++;
        if (rdy !== 1'b0 || cerr !== 1'b0 || sfault !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b code_err=%b supply_fault=%b, required 000", rdy, cerr, sfault);
        end
        chk_undriven("reset_outputs");
        rst = 1'b0;
        tick();
        chk_undriven("off_after_reset");
    endtask

    task automatic test_power_up();
        pdb = 1'b1;
        tick(); chk_undriven("wake_sync_1");
        tick(); chk_undriven("wake_sync_2");
        for (int i = 0; i < 8; i++) begin
            tick(); chk_zero("wake_zero_code");
        end
        tick();
        checks++;
        if (rdy !== 1'b1 || s_rdy !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise: ready=%b small_ready=%b, required 1 1", rdy, s_rdy);
        end
    endtask

    task automatic test_datapath();
        logic [23:0] q[$];
        logic [6:0]  sq[$];
        logic [23:0] e;
        logic [6:0]  se;
        logic [6:0]  b;
        logic [16:0] t;
        logic [3:0]  sb;
        logic [2:0]  st;
        for (int i = 0; i < 24; i++) begin
            if (q.size() == 2) begin
                e = q.pop_front();
                checks++;
                if (bo !== e[6:0] || bob !== ~e[6:0] || to !== e[23:7] || tob !== ~e[23:7]) begin
                    errors++;
                    $display("FAIL pipe_data: bin=%h binb=%h therm=%h thermb=%h, required %h %h %h %h",
                             bo, bob, to, tob, e[6:0], ~e[6:0], e[23:7], ~e[23:7]);
                end
            end
            if (sq.size() == 1) begin
                se = sq.pop_front();
                checks++;
                if (s_bo !== se[3:0] || s_bob !== ~se[3:0] || s_to !== se[6:4] || s_tob !== ~se[6:4]) begin
                    errors++;
                    $display("FAIL small_pipe_data: bin=%h therm=%h, required %h %h", s_bo, s_to, se[3:0], se[6:4]);
                end
            end
            b  = (i == 0) ? 7'h55 : 7'($urandom);
            t  = (i == 1) ? 17'h1FFFF : 17'($urandom);
            sb = 4'($urandom);
            st = 3'($urandom);
            set_data(b, t);
            s_din = sb; s_dinb = ~sb; s_dth = st; s_dthb = ~st;
            q.push_back({t, b});
            sq.push_back({st, sb});
            tick();
        end
    endtask

    task automatic test_code_err();
        logic [16:0] t;
        t = 17'h00FF0;
        set_data(7'h11, t);
        dthb = ~t ^ 17'h00001;
        tick();
        set_data(7'h11, t);
        checks++;
        if (cerr !== 1'b1) begin
            errors++;
            $display("FAIL code_err_set: code_err=%b, required 1", cerr);
        end
        tick(); tick(); tick();
        checks++;
        if (cerr !== 1'b1 || s_cerr !== 1'b0) begin
            errors++;
            $display("FAIL code_err_sticky: code_err=%b small=%b, required 1 0", cerr, s_cerr);
        end
        checks++;
        if (tob !== ~to || to !== t) begin
            errors++;
            $display("FAIL thermb_complement: therm=%h thermb=%h, required %h %h", to, tob, t, ~t);
        end
    endtask

    task automatic test_supply_boundary();
        v18 = 1.89;
        tick(); tick(); tick();
        checks++;
        if (rdy !== 1'b1 || sfault !== 1'b0) begin
            errors++;
            $display("FAIL vdd18_edge: ready=%b supply_fault=%b, required 1 0", rdy, sfault);
        end
        v18 = 1.8;
    endtask

    task automatic test_power_down();
        pdb = 1'b0;
        tick(); tick();
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL ready_hold_sync: ready=%b, required 1", rdy);
        end
        tick(); chk_zero("drain_zero_0");
        pdb = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick(); chk_zero("drain_zero");
        end
        tick(); chk_undriven("drain_to_off");
        tick(); chk_zero("rewake_after_off");
        wait_ready("rewake_ready");
    endtask

    task automatic test_supply_fault();
        v08 = 0.75;
        tick();
        chk_undriven("fault_outputs");
        checks++;
        if (sfault !== 1'b1 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL fault_flag: supply_fault=%b ready=%b, required 1 0", sfault, rdy);
        end
        tick();
        chk_undriven("fault_hold_off");
        v08 = 0.8;
        tick();
        chk_zero("fault_rewake");
        wait_ready("fault_rewake_ready");
        checks++;
        if (sfault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: supply_fault=%b, required 1", sfault);
        end
    endtask

    task automatic test_rst_in_wake();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_zero("in_wake_before_rst");
        rst = 1'b1;
        tick();
        chk_undriven("rst_in_wake_outputs");
        checks++;
        if (rdy !== 1'b0 || cerr !== 1'b0 || sfault !== 1'b0 || s_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_wake_flags: ready=%b code_err=%b supply_fault=%b, required 000",
                     rdy, cerr, sfault);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_datapath();
        test_code_err();
        test_supply_boundary();
        test_power_down();
        test_supply_fault();
        test_rst_in_wake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
